// File: rtl/multiport_fifo.sv
// multiport_fifo: superscalar circular FIFO for the wide instruction/uop queue.
// Each cycle it accepts up to N_ENQ entries and releases up to N_DEQ entries, in order.
// Lanes only handshake as a contiguous prefix starting at lane 0.
//
// Ports:
//   clk, rst     clock and synchronous active-high reset (clears counters and storage)
//   flush        synchronous clear of all queued entries (storage untouched)
//   enq_valid    per-lane enqueue request, lane 0 oldest
//   enq_ready    lane i may be accepted this cycle
//   enq_data     lane i at [i*ENTRY_WIDTH +: ENTRY_WIDTH]
//   deq_valid    lane j holds the j-th oldest entry
//   deq_ready    per-lane consumer accept
//   deq_data     lane 0 is the head entry
//   count        registered occupancy, 0..N_ENTRIES
//   almost_full  count >= AFULL_THRESH
//
// Build option: define FIFO_BYPASS_EN to let enqueue lanes flow straight to the dequeue
// lanes when the queue is empty (zero-cycle latency). Undefined: latency is always >= 1.
module multiport_fifo #(
    parameter int unsigned N_ENTRIES    = 8,
    parameter int unsigned ENTRY_WIDTH  = 32,
    parameter int unsigned N_ENQ        = 2,
    parameter int unsigned N_DEQ        = 2,
    parameter int unsigned AFULL_THRESH = 6
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            flush,
    input  logic [N_ENQ-1:0]                enq_valid,
    output logic [N_ENQ-1:0]                enq_ready,
    input  logic [N_ENQ*ENTRY_WIDTH-1:0]    enq_data,
    output logic [N_DEQ-1:0]                deq_valid,
    input  logic [N_DEQ-1:0]                deq_ready,
    output logic [N_DEQ*ENTRY_WIDTH-1:0]    deq_data,
    output logic [$clog2(N_ENTRIES):0]      count,
    output logic                            almost_full
);

    localparam int unsigned PTR_WIDTH = $clog2(N_ENTRIES);
    localparam int unsigned CTR_WIDTH = PTR_WIDTH + 1;

    typedef logic [CTR_WIDTH-1:0] ctr_t;
    typedef logic [PTR_WIDTH-1:0] ptr_t;

    ctr_t                   enq_ctr_q, enq_ctr_d;
    ctr_t                   deq_ctr_q, deq_ctr_d;
    logic [ENTRY_WIDTH-1:0] mem_q [N_ENTRIES];

    ptr_t                   enq_ptr;
    ptr_t                   deq_ptr;
    ctr_t                   n_enq;
    ctr_t                   n_deq;
    ctr_t                   n_byp;
    ctr_t                   n_wr;
    logic                   enq_gap;
    logic                   deq_gap;
    logic [ENTRY_WIDTH-1:0] wr_data [N_ENQ];

    assign enq_ptr     = enq_ctr_q[PTR_WIDTH-1:0];
    assign deq_ptr     = deq_ctr_q[PTR_WIDTH-1:0];
    assign count       = enq_ctr_q - deq_ctr_q;
    assign almost_full = count >= ctr_t'(AFULL_THRESH);

    // Ready depends only on the registered count, so a full queue blocks enqueue even when
    // a dequeue happens in the same cycle.
    always_comb begin
        for (int unsigned i = 0; i < N_ENQ; i++) begin
            enq_ready[i] = !flush && ((ctr_t'(N_ENTRIES) - count) > ctr_t'(i));
        end
    end

`ifdef FIFO_BYPASS_EN
    localparam int unsigned N_BYP = (N_ENQ < N_DEQ) ? N_ENQ : N_DEQ;
    logic bypass;
    assign bypass = !flush && (count == '0);
`endif

    always_comb begin
        for (int unsigned j = 0; j < N_DEQ; j++) begin
            deq_valid[j] = !flush && (count > ctr_t'(j));
            deq_data[j*ENTRY_WIDTH +: ENTRY_WIDTH] = mem_q[deq_ptr + ptr_t'(j)];
        end
`ifdef FIFO_BYPASS_EN
        if (bypass) begin
            for (int unsigned j = 0; j < N_BYP; j++) begin
                deq_valid[j] = enq_valid[j];
                deq_data[j*ENTRY_WIDTH +: ENTRY_WIDTH] = enq_data[j*ENTRY_WIDTH +: ENTRY_WIDTH];
            end
        end
`endif
    end

    // Leading-lane handshake counts; everything after the first gap is ignored.
    always_comb begin
        n_enq   = '0;
        enq_gap = 1'b0;
        for (int unsigned i = 0; i < N_ENQ; i++) begin
            if (!enq_gap && enq_valid[i] && enq_ready[i]) begin
                n_enq = n_enq + ctr_t'(1);
            end else begin
                enq_gap = 1'b1;
            end
        end
    end

    always_comb begin
        n_deq   = '0;
        deq_gap = 1'b0;
        for (int unsigned j = 0; j < N_DEQ; j++) begin
            if (!deq_gap && deq_valid[j] && deq_ready[j]) begin
                n_deq = n_deq + ctr_t'(1);
            end else begin
                deq_gap = 1'b1;
            end
        end
    end

    // While bypassing, every dequeue handshake consumes an enqueue lane directly, so those
    // lanes are neither written nor counted.
`ifdef FIFO_BYPASS_EN
    assign n_byp = bypass ? n_deq : '0;
`else
    assign n_byp = '0;
`endif

    assign n_wr = n_enq - n_byp;

    always_comb begin
        enq_ctr_d = enq_ctr_q + n_wr;
        deq_ctr_d = deq_ctr_q + n_deq - n_byp;
        // Write slot k takes the k-th lane after the bypassed ones.
        for (int unsigned k = 0; k < N_ENQ; k++) begin
            wr_data[k] = '0;
            for (int unsigned i = 0; i < N_ENQ; i++) begin
                if (ctr_t'(i) == ctr_t'(k) + n_byp) begin
                    wr_data[k] = enq_data[i*ENTRY_WIDTH +: ENTRY_WIDTH];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            enq_ctr_q <= '0;
            deq_ctr_q <= '0;
            for (int unsigned k = 0; k < N_ENTRIES; k++) begin
                mem_q[k] <= '0;
            end
        end else begin
            if (flush) begin
                enq_ctr_q <= '0;
                deq_ctr_q <= '0;
            end else begin
                enq_ctr_q <= enq_ctr_d;
                deq_ctr_q <= deq_ctr_d;
            end
            // n_wr is zero during flush because enq_ready is low.
            for (int unsigned k = 0; k < N_ENQ; k++) begin
                if (ctr_t'(k) < n_wr) begin
                    mem_q[enq_ptr + ptr_t'(k)] <= wr_data[k];
                end
            end
        end
    end

endmodule

// File: tb/tb_multiport_fifo.sv
// Scoreboard bench for multiport_fifo (8 entries, 2x2 lanes, 32-bit data, afull at 6).
module tb_multiport_fifo;

    localparam int EW = 32;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic [1:0]  enq_valid = 2'b00;
    logic [1:0]  enq_ready;
    logic [63:0] enq_data = '0;
    logic [1:0]  deq_valid;
    logic [1:0]  deq_ready = 2'b00;
    logic [63:0] deq_data;
    logic [3:0]  count;
    logic        almost_full;

    int          errors = 0;
    int          checks = 0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    multiport_fifo #(
        .N_ENTRIES    (8),
        .ENTRY_WIDTH  (32),
        .N_ENQ        (2),
        .N_DEQ        (2),
        .AFULL_THRESH (6)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .enq_valid   (enq_valid),
        .enq_ready   (enq_ready),
        .enq_data    (enq_data),
        .deq_valid   (deq_valid),
        .deq_ready   (deq_ready),
        .deq_data    (deq_data),
        .count       (count),
        .almost_full (almost_full)
    );

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic enq(input logic [1:0] v, input logic [31:0] d0, input logic [31:0] d1);
        enq_valid = v;
        enq_data  = {d1, d0};
    endtask

    // Monitor: every dequeue handshake pops the oldest expected entry.
    logic        mon_gap;
    logic [31:0] mon_exp;
    always @(negedge clk) begin
        if (!rst) begin
            mon_gap = 1'b0;
            for (int j = 0; j < 2; j++) begin
                if (!mon_gap && deq_valid[j] && deq_ready[j]) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL deq_lane%0d: got %0d but no entry expected", j,
                                 deq_data[j*EW +: EW]);
                    end else begin
                        mon_exp = exp_q.pop_front();
                        if (deq_data[j*EW +: EW] != mon_exp) begin
                            errors++;
                            $display("FAIL deq_lane%0d: got %0d expected %0d", j,
                                     deq_data[j*EW +: EW], mon_exp);
                        end
                    end
                end else begin
                    mon_gap = 1'b1;
                end
            end
        end
    end

    initial begin
        // Reset
        tick();
        rst = 1'b0;
        check("rst_count", count, 0);
        check("rst_deq_valid", deq_valid, 0);
        check("rst_enq_ready", enq_ready, 3);
        check("rst_almost_full", almost_full, 0);

        // 1: fill two per cycle
        for (int k = 0; k < 4; k++) begin
            enq(2'b11, 32'(2 * k + 1), 32'(2 * k + 2));
            exp_q.push_back(32'(2 * k + 1));
            exp_q.push_back(32'(2 * k + 2));
            tick();
            check("fill_count", count, 2 * (k + 1));
            check("fill_afull", almost_full, (k >= 2) ? 1 : 0);
        end
        enq_valid = 2'b00;
        check("full_enq_ready", enq_ready, 0);
        check("full_deq_valid", deq_valid, 3);

        // 2: drain two per cycle
        deq_ready = 2'b11;
        repeat (4) tick();
        deq_ready = 2'b00;
        check("drain_count", count, 0);
        check("drain_deq_valid", deq_valid, 0);
        check("drain_afull", almost_full, 0);

        // 3: full queue with simultaneous enq and deq
        for (int k = 0; k < 4; k++) begin
            enq(2'b11, 32'(11 + 2 * k), 32'(12 + 2 * k));
            exp_q.push_back(32'(11 + 2 * k));
            exp_q.push_back(32'(12 + 2 * k));
            tick();
        end
        check("refill_count", count, 8);
        enq(2'b11, 32'd99, 32'd98);
        deq_ready = 2'b11;
        tick();
        enq_valid = 2'b00;
        check("full_enqdeq_count", count, 6);
        repeat (3) tick();
        deq_ready = 2'b00;
        check("drain3_count", count, 0);

        // 4: steady state across pointer wrap
        enq(2'b11, 32'd1, 32'd2);
        exp_q.push_back(32'd1);
        exp_q.push_back(32'd2);
        tick();
        check("steady_prime_count", count, 2);
        deq_ready = 2'b11;
        for (int c = 1; c < 20; c++) begin
            enq(2'b11, 32'(2 * c + 1), 32'(2 * c + 2));
            exp_q.push_back(32'(2 * c + 1));
            exp_q.push_back(32'(2 * c + 2));
            tick();
            check("steady_count", count, 2);
        end
        enq_valid = 2'b00;
        tick();
        deq_ready = 2'b00;
        check("steady_end_count", count, 0);

        // 5: flush at count 5 with enqueue requested
        enq(2'b11, 32'd101, 32'd102);
        exp_q.push_back(32'd101);
        exp_q.push_back(32'd102);
        tick();
        enq(2'b11, 32'd103, 32'd104);
        exp_q.push_back(32'd103);
        exp_q.push_back(32'd104);
        tick();
        enq(2'b01, 32'd105, 32'd0);
        exp_q.push_back(32'd105);
        tick();
        check("pre_flush_count", count, 5);
        flush = 1'b1;
        enq(2'b11, 32'd201, 32'd202);
        exp_q.delete();
        #1;
        check("flush_enq_ready", enq_ready, 0);
        check("flush_deq_valid", deq_valid, 0);
        tick();
        flush = 1'b0;
        enq_valid = 2'b00;
        check("post_flush_count", count, 0);
        check("post_flush_deq_valid", deq_valid, 0);
        enq(2'b10, 32'd301, 32'd302);
        tick();
        enq_valid = 2'b00;
        check("gap_enq_count", count, 0);
        enq(2'b11, 32'd401, 32'd402);
        exp_q.push_back(32'd401);
        exp_q.push_back(32'd402);
        tick();
        enq_valid = 2'b00;
        check("two_count", count, 2);
        deq_ready = 2'b01;
        tick();
        check("single_deq_count", count, 1);
        tick();
        deq_ready = 2'b00;
        check("single_deq2_count", count, 0);

        // 6: enqueue into empty queue with lane-0 consumer ready
        enq(2'b11, 32'd9, 32'd10);
        exp_q.push_back(32'd9);
        exp_q.push_back(32'd10);
        deq_ready = 2'b01;
        #1;
`ifdef FIFO_BYPASS_EN
        check("byp_deq_valid0", deq_valid[0], 1);
        check("byp_deq_data0", deq_data[31:0], 9);
        tick();
        enq_valid = 2'b00;
        check("byp_count", count, 1);
        check("byp_head", deq_data[31:0], 10);
        tick();
        deq_ready = 2'b00;
        check("byp_end_count", count, 0);
`else
        check("nobyp_deq_valid", deq_valid, 0);
        tick();
        enq_valid = 2'b00;
        check("nobyp_count", count, 2);
        deq_ready = 2'b11;
        tick();
        deq_ready = 2'b00;
        check("nobyp_end_count", count, 0);
`endif

        tick();
        check("scoreboard_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
